vga_timing_gen: RTL and testbench

Parametrised VGA timing generator for the display path. Derives a pixel-enable strobe from clk_50, runs horizontal and vertical counters over configurable porch and sync timing, and produces sync outputs with programmable polarity. Sync, data-enable and blanked RGB are delayed to match frame-buffer read latency. Start and stop are clean, at frame boundaries only. The frame buffer and circle-drawing logic consume x, y, frame_start and line_start.

---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_timing_gen_if.sv | 35 +++
 rtl/vga_delay_line.sv | 28 ++
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 tb/tb_vga_timing_gen.sv | 369 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults and types
package vga_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel-side bundle between the timing generator and its consumers
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  import vga_pkg::*;

  logic          enable;
  rgb_t          rgb_in;
  logic          pix_en;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic          active;
  logic          line_start;
  logic          frame_start;
  logic          h_sync;
  logic          v_sync;
  logic          de;
  logic [7:0]    R_dac;
  logic [7:0]    G_dac;
  logic [7:0]    B_dac;
  logic          busy;

  modport master (
    input  enable, rgb_in,
    output pix_en, x, y, active, line_start, frame_start,
           h_sync, v_sync, de, R_dac, G_dac, B_dac, busy
  );

  modport slave (
    output enable, rgb_in,
    input  pix_en, x, y, active, line_start, frame_start,
           h_sync, v_sync, de, R_dac, G_dac, B_dac, busy
  );

endinterface

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - DEPTH-stage shift register plus one output register, stepped by adv
module vga_delay_line #(
  parameter int               DEPTH = 2,
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] FILL  = '0
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             clear,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH+1];

  always_ff @(posedge clk_50) begin
    if (reset || clear) begin
      for (int i = 0; i <= DEPTH; i++) stage[i] <= FILL;
    end else if (adv) begin
      stage[0] <= din;
      for (int i = 1; i <= DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA timing generator with frame-aligned start/stop and latency-matched outputs
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int PIPE_LAT = 2,
  parameter int CW       = 10
) (
  input  logic              clk_50,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DLW     = 27;

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0]  X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]  Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]  X_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0]  Y_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0]  HS_ON    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0]  HS_OFF   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0]  VS_ON    = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0]  VS_OFF   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [DLW-1:0] DL_FILL  = {~HS_POL, ~VS_POL, 25'd0};

  state_e         state;
  state_e         state_nxt;
  logic [DW-1:0]  div_q;
  logic [CW-1:0]  x_q;
  logic [CW-1:0]  y_q;
  logic           pix_en;
  logic           frame_end;
  logic           act;
  logic           hs_lvl;
  logic           vs_lvl;
  logic [DLW-1:0] dl_in;
  logic [DLW-1:0] dl_out;
  logic           de_d;
  rgb_t           rgb_d;

  assign pix_en    = (state != IDLE) && (div_q == DIV_LAST);
  assign frame_end = pix_en && (x_q == X_LAST) && (y_q == Y_LAST);

  always_ff @(posedge clk_50) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A stop request only parks the FSM in DRAIN; IDLE is reached on the last pixel of the frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vga.enable) state_nxt = RUN;
      RUN:     if (!vga.enable) state_nxt = DRAIN;
      DRAIN: begin
        if (vga.enable)     state_nxt = RUN;
        else if (frame_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset || state == IDLE) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (pix_en) begin
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  assign act    = (x_q < X_ACT) && (y_q < Y_ACT);
  assign hs_lvl = ((x_q >= HS_ON) && (x_q < HS_OFF)) ? HS_POL : ~HS_POL;
  assign vs_lvl = ((y_q >= VS_ON) && (y_q < VS_OFF)) ? VS_POL : ~VS_POL;
  assign dl_in  = {hs_lvl, vs_lvl, act, vga.rgb_in};

  // Flushing in IDLE guarantees deasserted outputs and no stale pixels on the next start.
  vga_delay_line #(
    .DEPTH (PIPE_LAT),
    .WIDTH (DLW),
    .FILL  (DL_FILL)
  ) u_delay (
    .clk_50 (clk_50),
    .reset  (reset),
    .clear  (state == IDLE),
    .adv    (pix_en),
    .din    (dl_in),
    .dout   (dl_out)
  );

  assign de_d  = dl_out[24];
  assign rgb_d = rgb_t'(dl_out[23:0]);

  assign vga.pix_en      = pix_en;
  assign vga.x           = x_q;
  assign vga.y           = y_q;
  assign vga.active      = act;
  assign vga.line_start  = pix_en && (x_q == '0);
  assign vga.frame_start = pix_en && (x_q == '0) && (y_q == '0);
  assign vga.h_sync      = dl_out[26];
  assign vga.v_sync      = dl_out[25];
  assign vga.de          = de_d;
  assign vga.R_dac       = de_d ? rgb_d.r : 8'd0;
  assign vga.G_dac       = de_d ? rgb_d.g : 8'd0;
  assign vga.B_dac       = de_d ? rgb_d.b : 8'd0;
  assign vga.busy        = (state != IDLE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of timing, pipeline alignment, stop/restart and reset
`timescale 1ns/1ps
module tb_vga_timing_gen;
  localparam int CW = 6;

  logic clk_50 = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always #5 clk_50 = ~clk_50;

  vga_timing_gen_if #(.CW(CW)) va ();
  vga_timing_gen_if #(.CW(CW)) vb ();

  // Small 16x9 raster: sync x 10..12, sync y 5..6, active 8x4.
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b0), .VS_POL(1'b0), .CLK_DIV(2), .PIPE_LAT(0), .CW(CW)
  ) dut_a (.clk_50(clk_50), .reset(reset), .vga(va));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .PIPE_LAT(2), .CW(CW)
  ) dut_b (.clk_50(clk_50), .reset(reset), .vga(vb));

  assign va.enable = enable;
  assign vb.enable = enable;
  assign va.rgb_in = {8'h12, 8'h34, 8'h56};
  assign vb.rgb_in = {2'b00, vb.x, 8'hA5, 2'b00, vb.y};

  task automatic strobe_a(output bit ok, output int sx, output int sy, output logic fs,
                          output logic ls, output logic hs, output logic vs, output logic d,
                          output logic [7:0] r);
    ok = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_50);
      if (va.pix_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    sx = int'(va.x);
    sy = int'(va.y);
    fs = va.frame_start;
    ls = va.line_start;
    @(negedge clk_50);
    hs = va.h_sync;
    vs = va.v_sync;
    d  = va.de;
    r  = va.R_dac;
  endtask

  task automatic test_reset();
    logic [40:0] obs_a;
    logic [4:0]  obs_b;
    enable = 1'b0;
    reset  = 1'b1;
    repeat (3) @(negedge clk_50);
    obs_a = {va.x, va.y, va.pix_en, va.de, va.R_dac, va.G_dac, va.B_dac, va.h_sync, va.v_sync, va.busy};
    n_cmp++;
    if (obs_a !== {6'd0, 6'd0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_a: got %h want %h", obs_a, {6'd0, 6'd0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0});
    end
    obs_b = {vb.pix_en, vb.de, vb.h_sync, vb.v_sync, vb.busy};
    n_cmp++;
    if (obs_b !== 5'b00000) begin
      n_bad++;
      $display("FAIL reset_b_pol: got %b want 00000", obs_b);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk_50);
    n_cmp++;
    if ({va.busy, va.pix_en, va.x} !== 8'd0) begin
      n_bad++;
      $display("FAIL idle_hold: got %h want 00", {va.busy, va.pix_en, va.x});
    end
  endtask

  task automatic test_start();
    enable = 1'b1;
    @(negedge clk_50);
    n_cmp++;
    if ({va.busy, va.pix_en, vb.pix_en, vb.frame_start} !== 4'b1011) begin
      n_bad++;
      $display("FAIL start_cycle1: got %b want 1011", {va.busy, va.pix_en, vb.pix_en, vb.frame_start});
    end
    @(negedge clk_50);
    n_cmp++;
    if ({va.pix_en, va.frame_start, va.line_start, va.x} !== {3'b111, 6'd0}) begin
      n_bad++;
      $display("FAIL first_strobe: got %h want %h", {va.pix_en, va.frame_start, va.line_start, va.x}, {3'b111, 6'd0});
    end
    @(negedge clk_50);
    n_cmp++;
    if ({va.pix_en, va.x, vb.x} !== {1'b0, 6'd1, 6'd2}) begin
      n_bad++;
      $display("FAIL strobe_gap: got %h want %h", {va.pix_en, va.x, vb.x}, {1'b0, 6'd1, 6'd2});
    end
    @(negedge clk_50);
    n_cmp++;
    if ({va.pix_en, va.x} !== {1'b1, 6'd1}) begin
      n_bad++;
      $display("FAIL strobe_period: got %h want %h", {va.pix_en, va.x}, {1'b1, 6'd1});
    end
  endtask

  task automatic test_horizontal();
    bit ok;
    int sx, sy;
    logic fs, ls, hs, vs, d;
    logic [7:0] r;
    int hs_low = 0, fall_x = -1, rise_x = -1, de_cnt = 0, blank_bad = 0, ls_cnt = 0, tmo = 0;
    bit done = 1'b0;
    for (int i = 0; i < 48 && !done; i++) begin
      strobe_a(ok, sx, sy, fs, ls, hs, vs, d, r);
      if (!ok) tmo++;
      if (sy == 1) begin
        if (hs === 1'b0) begin
          hs_low++;
          if (fall_x < 0) fall_x = sx;
        end else if (fall_x >= 0 && rise_x < 0) begin
          rise_x = sx;
        end
        if (d === 1'b1) de_cnt++;
        else if (r !== 8'h00) blank_bad++;
        if (ls === 1'b1) ls_cnt++;
        if (sx == 15) done = 1'b1;
      end
    end
    n_cmp++;
    if (!done || tmo != 0) begin n_bad++; $display("FAIL h_line_seen: got done=%0d tmo=%0d want 1/0", done, tmo); end
    n_cmp++;
    if (fall_x != 10) begin n_bad++; $display("FAIL hs_fall_x: got %0d want 10", fall_x); end
    n_cmp++;
    if (rise_x != 13) begin n_bad++; $display("FAIL hs_rise_x: got %0d want 13", rise_x); end
    n_cmp++;
    if (hs_low != 3) begin n_bad++; $display("FAIL hs_width: got %0d want 3", hs_low); end
    n_cmp++;
    if (de_cnt != 8) begin n_bad++; $display("FAIL de_width: got %0d want 8", de_cnt); end
    n_cmp++;
    if (blank_bad != 0 || ls_cnt != 1) begin
      n_bad++;
      $display("FAIL h_blank_ls: got blank=%0d ls=%0d want 0/1", blank_bad, ls_cnt);
    end
  endtask

  task automatic test_vertical();
    bit ok;
    int sx, sy;
    logic fs, ls, hs, vs, d;
    logic [7:0] r;
    int vs_low = 0, vs_y = -1, de_cnt = 0, de_late = 0, ls_cnt = 0, tmo = 0;
    logic fs_wrap = 1'b0;
    bit done = 1'b0;
    for (int i = 0; i < 160 && !done; i++) begin
      strobe_a(ok, sx, sy, fs, ls, hs, vs, d, r);
      if (!ok) tmo++;
      if (sx == 0 && sy == 0) begin
        done    = 1'b1;
        fs_wrap = fs;
      end else begin
        if (vs === 1'b0) begin
          vs_low++;
          if (vs_y < 0) vs_y = sy;
        end
        if (d === 1'b1) begin
          de_cnt++;
          if (sy >= 4) de_late++;
        end
        if (ls === 1'b1) ls_cnt++;
      end
    end
    n_cmp++;
    if (!done || tmo != 0 || fs_wrap !== 1'b1) begin
      n_bad++;
      $display("FAIL v_wrap_fs: got done=%0d tmo=%0d fs=%b want 1/0/1", done, tmo, fs_wrap);
    end
    n_cmp++;
    if (vs_low != 32 || vs_y != 5) begin
      n_bad++;
      $display("FAIL vs_width: got %0d strobes from y=%0d want 32 from y=5", vs_low, vs_y);
    end
    n_cmp++;
    if (de_cnt != 16 || de_late != 0) begin
      n_bad++;
      $display("FAIL v_de: got de=%0d late=%0d want 16/0", de_cnt, de_late);
    end
    n_cmp++;
    if (ls_cnt != 7) begin n_bad++; $display("FAIL line_starts: got %0d want 7", ls_cnt); end
  endtask

  task automatic test_frame_period();
    int cycles = 1;
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk_50);
      cycles++;
      if (va.frame_start === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found || cycles != 288) begin
      n_bad++;
      $display("FAIL frame_period: got %0d (found=%0d) want 288", cycles, found);
    end
  endtask

  task automatic test_pipeline();
    logic [26:0] obs, exp;
    logic [11:0] pos, pos_e;
    int p, px, py, q;
    logic act_e, hs_e, vs_e;
    logic [7:0] r_e, g_e, b_e;
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk_50);
    reset  = 1'b0;
    enable = 1'b1;
    for (int j = 1; j <= 160; j++) begin
      @(negedge clk_50);
      q     = j - 1;
      pos   = {vb.x, vb.y};
      pos_e = {6'(q % 16), 6'((q / 16) % 9)};
      n_cmp++;
      if (pos !== pos_e) begin n_bad++; $display("FAIL pipe_pos j=%0d: got %h want %h", j, pos, pos_e); end
      p = j - 4;
      if (p < 0) begin
        exp = 27'd0;
      end else begin
        px    = p % 16;
        py    = (p / 16) % 9;
        act_e = (px < 8) && (py < 4);
        hs_e  = (px >= 10) && (px < 13);
        vs_e  = (py >= 5) && (py < 7);
        r_e   = act_e ? 8'(px) : 8'd0;
        g_e   = act_e ? 8'hA5 : 8'd0;
        b_e   = act_e ? 8'(py) : 8'd0;
        exp   = {hs_e, vs_e, act_e, r_e, g_e, b_e};
      end
      obs = {vb.h_sync, vb.v_sync, vb.de, vb.R_dac, vb.G_dac, vb.B_dac};
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL pipe_out j=%0d: got %h want %h", j, obs, exp); end
    end
  endtask

  task automatic test_stop();
    bit ok;
    int sx, sy, tmo = 0, hs_lo = 0, vs_lo = 0;
    logic fs, ls, hs, vs, d;
    logic [7:0] r;
    bit found = 1'b0, drained = 1'b0, early = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      strobe_a(ok, sx, sy, fs, ls, hs, vs, d, r);
      if (!ok) tmo++;
      if (sy == 2) found = 1'b1;
    end
    enable = 1'b0;
    for (int i = 0; i < 400 && !drained; i++) begin
      @(negedge clk_50);
      if (va.busy !== 1'b1) early = 1'b1;
      if (va.h_sync === 1'b0) hs_lo++;
      if (va.v_sync === 1'b0) vs_lo++;
      if (va.pix_en === 1'b1 && va.x == 6'd15 && va.y == 6'd8) drained = 1'b1;
    end
    n_cmp++;
    if (!found || tmo != 0 || !drained || early) begin
      n_bad++;
      $display("FAIL drain_busy: got found=%0d tmo=%0d drained=%0d early=%0d want 1/0/1/0", found, tmo, drained, early);
    end
    n_cmp++;
    if (hs_lo != 42 || vs_lo != 64) begin
      n_bad++;
      $display("FAIL drain_syncs: got hs=%0d vs=%0d want 42/64", hs_lo, vs_lo);
    end
    @(negedge clk_50);
    n_cmp++;
    if ({va.busy, va.pix_en, va.x, va.y, va.h_sync, va.v_sync, va.de} !== {2'b00, 12'd0, 3'b110}) begin
      n_bad++;
      $display("FAIL idle_after_drain: got %h want %h", {va.busy, va.pix_en, va.x, va.y, va.h_sync, va.v_sync, va.de}, {2'b00, 12'd0, 3'b110});
    end
    repeat (4) @(negedge clk_50);
    n_cmp++;
    if ({va.busy, va.x, va.y} !== 13'd0) begin
      n_bad++;
      $display("FAIL idle_stays: got %h want 0", {va.busy, va.x, va.y});
    end
  endtask

  task automatic test_restart();
    bit ok;
    int sx, sy, px = -1, py = 0, nx, ny, glitch = 0, tmo = 0, fs_cnt = 0;
    logic fs, ls, hs, vs, d;
    logic [7:0] r;
    enable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      strobe_a(ok, sx, sy, fs, ls, hs, vs, d, r);
      if (!ok) tmo++;
      if (fs === 1'b1) fs_cnt++;
      if (px < 0) begin
        if (sx != 0 || sy != 0) glitch++;
      end else begin
        nx = (px == 15) ? 0 : px + 1;
        ny = (px == 15) ? ((py == 8) ? 0 : py + 1) : py;
        if (sx != nx || sy != ny) glitch++;
      end
      px = sx;
      py = sy;
      if (k == 40) enable = 1'b0;
      if (k == 43) enable = 1'b1;
    end
    n_cmp++;
    if (glitch != 0 || tmo != 0) begin
      n_bad++;
      $display("FAIL restart_glitch: got glitch=%0d tmo=%0d want 0/0", glitch, tmo);
    end
    n_cmp++;
    if (fs_cnt != 2 || va.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL restart_run: got fs=%0d busy=%b want 2/1", fs_cnt, va.busy);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk_50);
      if (va.pix_en === 1'b1 && va.x == 6'd11 && va.y == 6'd2) found = 1'b1;
    end
    n_cmp++;
    if (!found || va.h_sync !== 1'b0) begin
      n_bad++;
      $display("FAIL hs_before_reset: got found=%0d hs=%b want 1/0", found, va.h_sync);
    end
    reset = 1'b1;
    @(negedge clk_50);
    n_cmp++;
    if ({va.busy, va.pix_en, va.x, va.y, va.h_sync, va.v_sync, va.de, va.R_dac} !== {2'b00, 12'd0, 3'b110, 8'd0}) begin
      n_bad++;
      $display("FAIL reset_mid_a: got %h want %h", {va.busy, va.pix_en, va.x, va.y, va.h_sync, va.v_sync, va.de, va.R_dac}, {2'b00, 12'd0, 3'b110, 8'd0});
    end
    n_cmp++;
    if ({vb.busy, vb.x, vb.y, vb.h_sync, vb.v_sync, vb.de} !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_mid_b: got %h want 0", {vb.busy, vb.x, vb.y, vb.h_sync, vb.v_sync, vb.de});
    end
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk_50);
  endtask

  initial begin
    test_reset();
    test_start();
    test_horizontal();
    test_vertical();
    test_frame_period();
    test_pipeline();
    test_stop();
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
